// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
// Stage-control sequencer for the five-stage WISC-F18 pipeline. It turns
// stall and redirect requests from the hazard detector, the branch resolver,
// the cache miss FSMs and the HLT decoder into per-stage pipeline-register
// write enables, bubble injects and flushes. It also sequences the halt
// drain and keeps a saturating stall-cycle counter.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   hd_stall          hazard detector: hold IF/ID, bubble ID/EX
//   br_taken          branch in ID resolved taken (PC loads target)
//   icache_busy       I-cache miss fill in progress (level)
//   dcache_busy       D-cache miss fill in progress (level)
//   halt_id, halt_wb  HLT decoded in ID / HLT reached WB
//   *_write_en        pipeline-register load enables
//   IFID_flush        IF/ID loads a NOP
//   IDEX_bubble       ID/EX loads zeroed control
//   MEMWB_bubble      MEM/WB loads zeroed control
//   halted            processor halted
//   stall_count       saturating count of cycles with PC_write_en=0
//                     outside HALTED
module pipeline_stall_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hd_stall,
   input  logic             br_taken,
   input  logic             icache_busy,
   input  logic             dcache_busy,
   input  logic             halt_id,
   input  logic             halt_wb,
   output logic             PC_write_en,
   output logic             IFID_write_en,
   output logic             IFID_flush,
   output logic             IDEX_write_en,
   output logic             IDEX_bubble,
   output logic             EXMEM_write_en,
   output logic             MEMWB_write_en,
   output logic             MEMWB_bubble,
   output logic             halted,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   state_t state;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Priority-ordered decode; the first matching condition wins.
   always_comb begin
      PC_write_en    = 1'b1;
      IFID_write_en  = 1'b1;
      IFID_flush     = 1'b0;
      IDEX_write_en  = 1'b1;
      IDEX_bubble    = 1'b0;
      EXMEM_write_en = 1'b1;
      MEMWB_write_en = 1'b1;
      MEMWB_bubble   = 1'b0;
      halted         = 1'b0;
      if (!rst_n) begin
         // Hold every register and present NOPs while reset is asserted.
         PC_write_en    = 1'b0;
         IFID_write_en  = 1'b0;
         IFID_flush     = 1'b1;
         IDEX_write_en  = 1'b0;
         IDEX_bubble    = 1'b1;
         EXMEM_write_en = 1'b0;
         MEMWB_write_en = 1'b0;
         MEMWB_bubble   = 1'b1;
      end else if (state == HALTED) begin
         PC_write_en    = 1'b0;
         IFID_write_en  = 1'b0;
         IDEX_write_en  = 1'b0;
         EXMEM_write_en = 1'b0;
         MEMWB_write_en = 1'b0;
         halted         = 1'b1;
      end else if (dcache_busy) begin
         // MEM/WB keeps loading, but with a bubble, so WB never repeats a write.
         PC_write_en    = 1'b0;
         IFID_write_en  = 1'b0;
         IDEX_write_en  = 1'b0;
         EXMEM_write_en = 1'b0;
         MEMWB_bubble   = 1'b1;
      end else if (state == DRAIN) begin
         PC_write_en = 1'b0;
         IFID_flush  = 1'b1;
      end else if (icache_busy && (hd_stall || br_taken)) begin
         // ID holds so a pending branch re-resolves once the fill completes.
         PC_write_en   = 1'b0;
         IFID_write_en = 1'b0;
         IDEX_bubble   = 1'b1;
      end else if (icache_busy) begin
         PC_write_en = 1'b0;
         IFID_flush  = 1'b1;
      end else if (hd_stall) begin
         // A coincident br_taken is dropped; the branch re-resolves next cycle.
         PC_write_en   = 1'b0;
         IFID_write_en = 1'b0;
         IDEX_bubble   = 1'b1;
      end else if (br_taken) begin
         IFID_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RUN;
         stall_count <= '0;
      end else begin
         case (state)
            RUN:     if (halt_id && !dcache_busy && !icache_busy && !hd_stall)
                        state <= DRAIN;
            DRAIN:   if (halt_wb && !dcache_busy)
                        state <= HALTED;
            HALTED:  state <= HALTED;
            default: state <= RUN;
         endcase
         if (state != HALTED && !PC_write_en)
            stall_count <= sat_inc(stall_count);
      end
   end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

   localparam int CNT_W = 4;

   // Output vector order:
   // {PC_we, IFID_we, IFID_flush, IDEX_we, IDEX_bubble, EXMEM_we, MEMWB_we, MEMWB_bubble, halted}
   localparam logic [8:0] NORM = 9'b1_1_0_1_0_1_1_0_0;
   localparam logic [8:0] HDS  = 9'b0_0_0_1_1_1_1_0_0;
   localparam logic [8:0] DFRZ = 9'b0_0_0_0_0_0_1_1_0;
   localparam logic [8:0] FLSH = 9'b0_1_1_1_0_1_1_0_0;
   localparam logic [8:0] BR   = 9'b1_1_1_1_0_1_1_0_0;
   localparam logic [8:0] HALT = 9'b0_0_0_0_0_0_0_0_1;
   localparam logic [8:0] RST  = 9'b0_0_1_0_1_0_0_1_0;

   typedef struct {
      logic [8:0]       outs;
      logic [CNT_W-1:0] cnt;
      string            name;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic hd_stall = 1'b0, br_taken = 1'b0, icache_busy = 1'b0;
   logic dcache_busy = 1'b0, halt_id = 1'b0, halt_wb = 1'b0;
   logic PC_write_en, IFID_write_en, IFID_flush, IDEX_write_en, IDEX_bubble;
   logic EXMEM_write_en, MEMWB_write_en, MEMWB_bubble, halted;
   logic [CNT_W-1:0] stall_count;

   exp_t sb[$];
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pipeline_stall_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .hd_stall(hd_stall), .br_taken(br_taken),
      .icache_busy(icache_busy), .dcache_busy(dcache_busy),
      .halt_id(halt_id), .halt_wb(halt_wb),
      .PC_write_en(PC_write_en), .IFID_write_en(IFID_write_en),
      .IFID_flush(IFID_flush), .IDEX_write_en(IDEX_write_en),
      .IDEX_bubble(IDEX_bubble), .EXMEM_write_en(EXMEM_write_en),
      .MEMWB_write_en(MEMWB_write_en), .MEMWB_bubble(MEMWB_bubble),
      .halted(halted), .stall_count(stall_count)
   );

   // Monitor: the DUT presents a control word every cycle; compare mid-cycle.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic [8:0] act;
         e = sb.pop_front();
         act = {PC_write_en, IFID_write_en, IFID_flush, IDEX_write_en, IDEX_bubble,
                EXMEM_write_en, MEMWB_write_en, MEMWB_bubble, halted};
         n_cmp++;
         if (act !== e.outs) begin
            n_bad++;
            $display("FAIL %s outs: got %b expected %b", e.name, act, e.outs);
         end
         n_cmp++;
         if (stall_count !== e.cnt) begin
            n_bad++;
            $display("FAIL %s stall_count: got %0d expected %0d", e.name, stall_count, e.cnt);
         end
      end
   end

   task automatic step(input string name, input logic hd, input logic br,
                       input logic ic, input logic dc, input logic hid,
                       input logic hwb, input logic [8:0] eo, input int ec);
      exp_t e;
      @(posedge clk); #1;
      rst_n = 1'b1;
      hd_stall = hd; br_taken = br; icache_busy = ic;
      dcache_busy = dc; halt_id = hid; halt_wb = hwb;
      e.outs = eo; e.cnt = CNT_W'(ec); e.name = name;
      sb.push_back(e);
   endtask

   // Asserts reset mid-cycle (with hd_stall left as-is) and checks the reset view.
   task automatic rst_step(input string name);
      exp_t e;
      @(posedge clk); #1;
      rst_n = 1'b0;
      e.outs = RST; e.cnt = '0; e.name = name;
      sb.push_back(e);
      @(posedge clk); #1;
      hd_stall = 1'b0; br_taken = 1'b0; icache_busy = 1'b0;
      dcache_busy = 1'b0; halt_id = 1'b0; halt_wb = 1'b0;
   endtask

   initial begin
      rst_step("reset");

      // Load-use stall
      step("ld_use", 1,0,0,0,0,0, HDS, 0);
      step("ld_use_after", 0,0,0,0,0,0, NORM, 1);
      step("ld_use_after2", 0,0,0,0,0,0, NORM, 1);

      // D-cache miss, 8 cycles, hd_stall/br_taken toggling
      for (int i = 0; i < 8; i++)
         step($sformatf("dmiss%0d", i), i[0], i[1], 0, 1, 0, 0, DFRZ, 1 + i);
      step("dmiss_release", 0,0,0,0,0,0, NORM, 9);
      rst_step("reset2");

      // I-cache miss with branch held
      for (int i = 0; i < 4; i++)
         step($sformatf("imiss_br%0d", i), 0, 1, 1, 0, 0, 0, HDS, i);
      step("imiss_br_release", 0,1,0,0,0,0, BR, 4);
      step("after_br", 0,0,0,0,0,0, NORM, 4);
      step("imiss_alone", 0,0,1,0,0,0, FLSH, 4);
      step("after_imiss", 0,0,0,0,0,0, NORM, 5);
      step("hd_br", 1,1,0,0,0,0, HDS, 5);
      step("after_hd_br", 0,0,0,0,0,0, NORM, 6);
      rst_step("reset3");

      // Halt entry blocked by hd_stall and icache_busy, then drain gated by D-miss
      step("halt_hd", 1,0,0,0,1,0, HDS, 0);
      step("still_run1", 0,0,0,0,0,0, NORM, 1);
      step("halt_ic", 0,0,1,0,1,0, FLSH, 1);
      step("still_run2", 0,0,0,0,0,0, NORM, 2);
      step("halt_id", 0,0,0,0,1,0, NORM, 2);
      step("drain1", 0,0,0,0,1,0, FLSH, 2);
      step("drain2", 0,1,0,0,0,0, FLSH, 3);
      step("drain_wb_dc", 0,0,0,1,0,1, DFRZ, 4);
      step("drain_wb", 0,0,0,0,0,1, FLSH, 5);
      step("halted1", 1,1,1,1,1,1, HALT, 6);
      step("halted2", 0,0,0,0,0,0, HALT, 6);
      rst_step("reset4");

      // Saturation, then reset mid-stall
      for (int i = 0; i < 20; i++)
         step($sformatf("sat%0d", i), 1,0,0,0,0,0, HDS, (i > 15) ? 15 : i);
      step("sat_hold", 1,0,0,0,0,0, HDS, 15);
      @(posedge clk); #1;
      begin
         exp_t e;
         rst_n = 1'b0;
         e.outs = RST; e.cnt = '0; e.name = "rst_mid_stall";
         sb.push_back(e);
      end
      step("after_rst", 0,0,0,0,0,0, NORM, 0);

      // Bounded wait for the monitor to drain the scoreboard
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: %0d pending expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stage-control sequencer for the five-stage WISC-F18 pipeline: it turns stall and redirect requests into per-stage pipeline-register write enables, bubble injects and flushes. Requests come from the hazard detector (load-use and flag/branch stalls), the branch resolver in ID, the I-cache and D-cache miss FSMs, and the HLT decoder. It also sequences the halt drain and keeps a saturating stall-cycle performance counter. It sits beside the pipeline registers and drives their enable, bubble and flush pins directly.

## Interface
Parameters:
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- hd_stall  input  1  hazard detector requests a one-cycle hold of IF/ID plus a bubble into ID/EX (active high).
- br_taken  input  1  branch or BR in ID resolved taken; PC is being loaded with the target.
- icache_busy  input  1  I-cache miss fill in progress (level).
- dcache_busy  input  1  D-cache miss fill in progress (level).
- halt_id  input  1  HLT (opcode 4'b1111) decoded in ID.
- halt_wb  input  1  HLT has reached WB.
- PC_write_en  output  1  PC register load enable.
- IFID_write_en  output  1  IF/ID load enable.
- IFID_flush  output  1  IF/ID loads a NOP instead of the fetched word.
- IDEX_write_en  output  1  ID/EX load enable.
- IDEX_bubble  output  1  ID/EX loads zeroed control (NOP).
- EXMEM_write_en  output  1  EX/MEM load enable.
- MEMWB_write_en  output  1  MEM/WB load enable.
- MEMWB_bubble  output  1  MEM/WB loads zeroed control.
- halted  output  1  processor halted.
- stall_count  output  CNT_W  saturating count of cycles with PC_write_en=0 outside HALTED.

## Operation
- State register: RUN, DRAIN, HALTED.
- Outputs are combinational from the current state and inputs, evaluated in this priority order; the first matching rule applies, and any output a rule does not name defaults to write_en=1 and bubble/flush=0:
  1. HALTED: every write_en=0, all bubble/flush=0, halted=1.
  2. dcache_busy (RUN or DRAIN): full freeze. PC, IFID, IDEX and EXMEM write_en=0. MEMWB_write_en=1 with MEMWB_bubble=1, so WB never repeats a write.
  3. DRAIN: PC_write_en=0, IFID_flush=1; downstream stages advance.
  4. icache_busy and (hd_stall or br_taken): PC_write_en=0, IFID_write_en=0, IDEX_bubble=1. ID holds, so a branch re-resolves after the fill.
  5. icache_busy alone: PC_write_en=0, IFID_flush=1.
  6. hd_stall: PC_write_en=0, IFID_write_en=0, IDEX_bubble=1. A coincident br_taken is ignored this cycle.
  7. br_taken: PC_write_en=1, IFID_flush=1.
  8. Otherwise all enables 1, no bubbles.
- State transitions:
  - RUN to DRAIN when halt_id=1 and none of dcache_busy, icache_busy or hd_stall is asserted. The HLT advances into EX that cycle.
  - DRAIN to HALTED when halt_wb=1 and dcache_busy=0.
  - HALTED is left only by reset.
  - halt_id in DRAIN is ignored.
- stall_count increments by 1 on each posedge where PC_write_en=0 and the state is not HALTED. It saturates at all-ones and never wraps.

## Timing
- Zero-latency control: outputs respond in the same cycle as their inputs.
- State and stall_count register at posedge clk.
- Reset (rst_n=0, asynchronous):
  - state=RUN, stall_count=0, halted=0.
  - While rst_n is low, every write_en=0, IFID_flush=1, IDEX_bubble=1 and MEMWB_bubble=1.
  - Normal decode resumes in the first cycle after rst_n rises.
- A reset asserted mid-DRAIN or mid-fill returns to RUN immediately. The cache FSMs own their own recovery.
- The busy inputs are levels. Freeze lasts exactly as long as the level is high, with no extra release cycle.

## Test plan
- Load-use: hd_stall=1 for 1 cycle in RUN -> PC_write_en=0, IFID_write_en=0, IDEX_bubble=1 that cycle; stall_count goes 0 to 1; next cycle all enables 1.
- D-miss: dcache_busy high for 8 cycles with hd_stall and br_taken toggling -> PC/IFID/IDEX/EXMEM write_en=0 and MEMWB_bubble=1 for all 8 cycles; stall_count=8.
- I-miss with branch: icache_busy high for 4 cycles and br_taken=1 throughout -> IFID_write_en=0 and IDEX_bubble=1 for 4 cycles; first cycle after the fill gives PC_write_en=1, IFID_flush=1.
- Halt: halt_id=1 in RUN, halt_wb=1 three cycles later -> DRAIN for 3 cycles with IFID_flush=1; then halted=1 and all enables 0; further inputs have no effect.
- Halt gated by D-miss: halt_wb=1 together with dcache_busy=1 -> stays in DRAIN; enters HALTED on the first cycle with dcache_busy=0 and halt_wb=1.
- Saturation and reset: with CNT_W=4, hold hd_stall for 20 cycles -> stall_count stops at 15; assert rst_n=0 mid-stall -> stall_count=0 and all enables 0 asynchronously.
